// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-requester, single-reader FIFO controller.
// Arbitrates two write requesters onto one shared storage array, owns the
// write/read pointers and decodes full/empty/level from the pointer state.
//
// Optional build macro: FIFO_WR_ARBITER_STRICT_PRIO_EN
//   defined   -> requester 0 always wins a tie (no round-robin state)
//   undefined -> round-robin between the two requesters (default)
//
// Handshake: reqN_valid/reqN_data must stay stable until reqN_ready is seen
// high; a write is transferred on every clk edge where reqN_valid and
// reqN_ready are both 1. reqN_ready is combinational from valid, full and the
// round-robin state, and is never high while rst is asserted.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  rd_inc,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
`ifndef FIFO_WR_ARBITER_STRICT_PRIO_EN
  // 1 when requester 1 received the most recent grant
  logic          last_q, last_d;
`endif

  logic empty_int;
  logic full_int;
  logic grant0;
  logic grant1;
  logic pop;

  // Status decode from registered pointers only
  always_comb begin
    empty_int = (wptr_q == rptr_q);
    full_int  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
  end

  // Grant selection: only when not full and not in reset, at most one grant
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !full_int) begin
`ifdef FIFO_WR_ARBITER_STRICT_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  // Next-state: pointer advances and round-robin history
  always_comb begin
    pop    = rd_inc && !empty_int && !rst;
    wptr_d = wptr_q + PW'(grant0 | grant1);
    rptr_d = rptr_q + PW'(pop);
`ifndef FIFO_WR_ARBITER_STRICT_PRIO_EN
    last_d = (grant0 || grant1) ? grant1 : last_q;
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
`ifndef FIFO_WR_ARBITER_STRICT_PRIO_EN
      last_q <= 1'b1;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
`ifndef FIFO_WR_ARBITER_STRICT_PRIO_EN
      last_q <= last_d;
`endif
    end
  end

  // Outputs; reset forces the idle/empty view even before the pointers clear
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    wclken     = grant0 | grant1;
    wr_data    = grant1 ? req1_data : req0_data;
    wr_addr    = rst ? '0 : wptr_q[ADDR_WIDTH-1:0];
    rd_addr    = rst ? '0 : rptr_q[ADDR_WIDTH-1:0];
    empty      = rst | empty_int;
    full       = !rst & full_int;
    level      = rst ? '0 : (wptr_q - rptr_q);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: a behavioural storage array is attached to
// the memory-side outputs, and a queue-based FIFO model predicts grants,
// addresses, status and read data.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req1_valid, rd_inc;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready, wclken, full, empty;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW:0]   level;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_inc(rd_inc), .wclken(wclken), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .full(full), .empty(empty), .level(level)
  );

  // Storage array: write on clk edge, combinational read
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) if (wclken) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];

  // Reference model: queue of stored entries, total push/pop counts, last grantee
  logic [DW-1:0] exp_q[$];
  int wcnt, rcnt, last_m;
  int tests, fails;

  function automatic int exp_grant(input logic v0, input logic v1);
    if (exp_q.size() == DEPTH) return -1;
`ifdef FIFO_WR_ARBITER_STRICT_PRIO_EN
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`else
    if (v0 && v1) return (last_m == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
`endif
  endfunction

  task automatic model_clear();
    exp_q.delete();
    wcnt = 0; rcnt = 0; last_m = 1;
  endtask

  // Driver: apply inputs at the current (negedge) time, let them settle
  task automatic drive(input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1, input logic rd);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    rd_inc = rd;
    #1;
  endtask

  // Advance one clock edge and update the model; returns at the next negedge
  task automatic commit();
    int g;
    logic pop_ok;
    logic [DW-1:0] d;
    g = exp_grant(req0_valid, req1_valid);
    pop_ok = rd_inc && (exp_q.size() > 0);
    d = (g == 1) ? req1_data : req0_data;
    @(posedge clk);
    if (pop_ok) begin
      void'(exp_q.pop_front());
      rcnt++;
    end
    if (g >= 0) begin
      exp_q.push_back(d);
      wcnt++;
      last_m = g;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b%0b exp 00", req0_ready, req1_ready); end
    tests++; if (wclken !== 1'b0) begin fails++; $display("FAIL reset_wclken: got %0b exp 0", wclken); end
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_status: empty %0b full %0b exp 1 0", empty, full); end
    tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d exp 0", level); end
    tests++; if (wr_addr !== 3'd0 || rd_addr !== 3'd0) begin fails++; $display("FAIL reset_addr: wr %0d rd %0d exp 0 0", wr_addr, rd_addr); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    model_clear();
  endtask

  task automatic test_single_push();
    do_reset();
    drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    tests++; if (req0_ready !== 1'b1 || wclken !== 1'b1) begin fails++; $display("FAIL push_grant: ready0 %0b wclken %0b exp 1 1", req0_ready, wclken); end
    tests++; if (wr_addr !== 3'd0 || wr_data !== 8'hA5) begin fails++; $display("FAIL push_wr: addr %0d data %h exp 0 a5", wr_addr, wr_data); end
    commit();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tests++; if (empty !== 1'b0 || level !== 4'd1) begin fails++; $display("FAIL push_status: empty %0b level %0d exp 0 1", empty, level); end
    tests++; if (rd_data !== 8'hA5) begin fails++; $display("FAIL push_rd_data: got %h exp a5", rd_data); end
  endtask

  task automatic test_contention();
    int       exp_g [4];
    logic [DW-1:0] exp_m [4];
`ifdef FIFO_WR_ARBITER_STRICT_PRIO_EN
    exp_g = '{0, 0, 0, 0};
    exp_m = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_g = '{0, 1, 0, 1};
    exp_m = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
      tests++;
      if (req0_ready !== (exp_g[i] == 0) || req1_ready !== (exp_g[i] == 1)) begin
        fails++; $display("FAIL contention_grant[%0d]: ready %0b%0b exp grant %0d", i, req1_ready, req0_ready, exp_g[i]);
      end
      commit();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[i] !== exp_m[i]) begin fails++; $display("FAIL contention_mem[%0d]: got %h exp %h", i, mem[i], exp_m[i]); end
    end
    tests++; if (level !== 4'd4) begin fails++; $display("FAIL contention_level: got %0d exp 4", level); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      commit();
    end
    drive(1'b1, 8'h99, 1'b1, 8'h66, 1'b0);
    tests++; if (full !== 1'b1 || level !== 4'd8) begin fails++; $display("FAIL full_status: full %0b level %0d exp 1 8", full, level); end
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || wclken !== 1'b0) begin fails++; $display("FAIL full_block: ready %0b%0b wclken %0b exp 0", req1_ready, req0_ready, wclken); end
    commit();
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    tests++; if (req0_ready !== 1'b0) begin fails++; $display("FAIL full_pushpop_ready: got %0b exp 0", req0_ready); end
    tests++; if (rd_data !== exp_q[0]) begin fails++; $display("FAIL full_rd_data: got %h exp %h", rd_data, exp_q[0]); end
    commit();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tests++; if (level !== 4'd7 || full !== 1'b0) begin fails++; $display("FAIL full_after_pop: level %0d full %0b exp 7 0", level, full); end
  endtask

  task automatic test_empty_pop();
    do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    commit();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tests++; if (rd_addr !== 3'd0 || level !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL empty_pop: rd_addr %0d level %0d empty %0b exp 0 0 1", rd_addr, level, empty); end
    drive(1'b1, 8'h5C, 1'b0, '0, 1'b1);
    tests++; if (req0_ready !== 1'b1) begin fails++; $display("FAIL empty_pushpop_ready: got %0b exp 1", req0_ready); end
    commit();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tests++; if (level !== 4'd1 || rd_addr !== 3'd0) begin fails++; $display("FAIL empty_pushpop: level %0d rd_addr %0d exp 1 0", level, rd_addr); end
    tests++; if (rd_data !== 8'h5C) begin fails++; $display("FAIL empty_pushpop_data: got %h exp 5c", rd_data); end
  endtask

  task automatic test_stream();
    logic sel;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sel = 1'($urandom_range(0, 1));
      drive(!sel, 8'($urandom), sel, 8'($urandom), 1'b1);
      tests++; if (wclken !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL stream_flow[%0d]: wclken %0b full %0b exp 1 0", i, wclken, full); end
      tests++; if (wr_addr !== 3'(wcnt) || rd_addr !== 3'(rcnt)) begin fails++; $display("FAIL stream_addr[%0d]: wr %0d rd %0d exp %0d %0d", i, wr_addr, rd_addr, wcnt % DEPTH, rcnt % DEPTH); end
      if (exp_q.size() > 0) begin
        tests++; if (rd_data !== exp_q[0]) begin fails++; $display("FAIL stream_data[%0d]: got %h exp %h", i, rd_data, exp_q[0]); end
      end
      commit();
    end
  endtask

  task automatic test_random();
    int   g;
    logic rd;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rd = (i < 100) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), rd);
      g = exp_grant(req0_valid, req1_valid);
      tests++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1) || wclken !== (g >= 0)) begin fails++; $display("FAIL rand_grant[%0d]: ready %0b%0b wclken %0b exp grant %0d", i, req1_ready, req0_ready, wclken, g); end
      tests++; if (wr_data !== ((g == 1) ? req1_data : req0_data)) begin fails++; $display("FAIL rand_wr_data[%0d]: got %h", i, wr_data); end
      tests++; if (level !== 4'(exp_q.size()) || full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin fails++; $display("FAIL rand_status[%0d]: level %0d full %0b empty %0b exp level %0d", i, level, full, empty, exp_q.size()); end
      tests++; if (wr_addr !== 3'(wcnt) || rd_addr !== 3'(rcnt)) begin fails++; $display("FAIL rand_addr[%0d]: wr %0d rd %0d exp %0d %0d", i, wr_addr, rd_addr, wcnt % DEPTH, rcnt % DEPTH); end
      if (exp_q.size() > 0) begin
        tests++; if (rd_data !== exp_q[0]) begin fails++; $display("FAIL rand_rd_data[%0d]: got %h exp %h", i, rd_data, exp_q[0]); end
      end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
      commit();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, '0, 1'b0);
      commit();
    end
    drive(1'b1, 8'h42, 1'b1, 8'h24, 1'b1);
    tests++; if (level !== 4'd5) begin fails++; $display("FAIL midrst_pre_level: got %0d exp 5", level); end
    rst = 1'b1;
    #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || wclken !== 1'b0) begin fails++; $display("FAIL midrst_ready: ready %0b%0b wclken %0b exp 0", req1_ready, req0_ready, wclken); end
    @(posedge clk);
    @(negedge clk);
    tests++; if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0) begin fails++; $display("FAIL midrst_status: empty %0b level %0d full %0b exp 1 0 0", empty, level, full); end
    tests++; if (wr_addr !== 3'd0 || rd_addr !== 3'd0 || req0_ready !== 1'b0) begin fails++; $display("FAIL midrst_held: wr %0d rd %0d ready0 %0b exp 0 0 0", wr_addr, rd_addr, req0_ready); end
    rst = 1'b0;
    model_clear();
    drive(1'b1, 8'h42, 1'b1, 8'h24, 1'b0);
    tests++; if (empty !== 1'b1 || wr_addr !== 3'd0 || rd_addr !== 3'd0) begin fails++; $display("FAIL midrst_ptrs: empty %0b wr %0d rd %0d exp 1 0 0", empty, wr_addr, rd_addr); end
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin fails++; $display("FAIL midrst_first_tie: ready %0b%0b exp 01", req1_ready, req0_ready); end
    commit();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tests++; if (level !== 4'd1 || rd_data !== 8'h42) begin fails++; $display("FAIL midrst_after: level %0d data %h exp 1 42", level, rd_data); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_clear();
    test_reset();
    test_single_push();
    test_contention();
    test_full();
    test_empty_pop();
    test_stream();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
